// File: rtl/capture_sequencer_if.sv
// Control bus between the capture run controller and the rest of the capture path.
//
// Signalling contract: there is no valid/ready pair on this bus. Every signal is
// a level sampled on the rising edge of the RAM clock. transfer_done is a level
// flag owned by the copy detector and only has meaning while the run is
// sweeping read addresses. wr_en qualifies ram_addr in the same cycle.
// push_button_n is raw and asynchronous; the controller synchronizes it.
interface capture_sequencer_if #(
  parameter int address_width = 14
);
  logic                     push_button_n;
  logic                     transfer_done;
  logic                     start_signal;
  logic                     enable;
  logic                     wr_en;
  logic [address_width-1:0] ram_addr;
  logic                     busy;
  logic                     done;
  logic [2:0]               dbg_state;

  // The run controller drives the bus.
  modport master (
    input  push_button_n,
    input  transfer_done,
    output start_signal,
    output enable,
    output wr_en,
    output ram_addr,
    output busy,
    output done,
    output dbg_state
  );

  // Consumers of the run controller (datapath, RAM, LEDs, button).
  modport slave (
    output push_button_n,
    output transfer_done,
    input  start_signal,
    input  enable,
    input  wr_en,
    input  ram_addr,
    input  busy,
    input  done,
    input  dbg_state
  );
endinterface

// File: rtl/capture_sequencer.sv
// Run controller for the DUT-to-RAM capture path (RAM clock domain).
// Debounces the push button, primes the datapath, lets the pipeline settle,
// writes one full capture into RAM, then sweeps read addresses until the copy
// detector reports completion. All outputs are registered.
module capture_sequencer #(
  parameter int address_width   = 14,
  parameter int max_ram_address = 4096,
  parameter int burst_index     = 5,
  parameter int debounce_cycles = 16,
  parameter int settle_cycles   = 8
) (
  input logic                 clk,
  input logic                 reset,
  capture_sequencer_if.master bus
);

  localparam int db_w   = $clog2(debounce_cycles + 1);
  localparam int ph_max = (burst_index > settle_cycles) ? burst_index : settle_cycles;
  localparam int ph_w   = $clog2(ph_max + 1);

  localparam logic [db_w-1:0]          db_full     = db_w'(debounce_cycles);
  localparam logic [db_w-1:0]          db_last     = db_w'(debounce_cycles - 1);
  localparam logic [ph_w-1:0]          prime_last  = ph_w'(burst_index - 1);
  localparam logic [ph_w-1:0]          settle_last = ph_w'(settle_cycles - 1);
  localparam logic [address_width-1:0] addr_last   = address_width'(max_ram_address - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_SETTLE,
    S_CAPTURE,
    S_READBACK,
    S_DONE
  } state_t;

  state_t                   state;
  logic                     btn_meta;
  logic                     btn_sync;
  logic [db_w-1:0]          db_cnt;
  logic                     press;
  logic [ph_w-1:0]          phase_cnt;
  logic                     start_r;
  logic                     enable_r;
  logic                     wr_en_r;
  logic [address_width-1:0] addr_r;
  logic                     busy_r;
  logic                     done_r;

  // Two-flop synchronizer for the asynchronous, active-low button; idles released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= bus.push_button_n;
      btn_sync <= btn_meta;
    end
  end

  // Count consecutive pressed samples, saturating so a held button fires only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
    end else if (btn_sync) begin
      db_cnt <= '0;
    end else if (db_cnt != db_full) begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // One-cycle press event: the cycle in which the counter steps onto its ceiling.
  assign press = ~btn_sync && (db_cnt == db_last);

  // Run sequencer; each branch loads the output registers for the state it enters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      start_r   <= 1'b1;
      enable_r  <= 1'b0;
      wr_en_r   <= 1'b0;
      addr_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (press) begin
            state     <= S_PRIME;
            phase_cnt <= '0;
            start_r   <= 1'b1;
            enable_r  <= 1'b1;
            wr_en_r   <= 1'b0;
            addr_r    <= '0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
          end
        end
        S_PRIME: begin
          if (phase_cnt == prime_last) begin
            state     <= S_SETTLE;
            phase_cnt <= '0;
            start_r   <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (phase_cnt == settle_last) begin
            state     <= S_CAPTURE;
            phase_cnt <= '0;
            wr_en_r   <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (addr_r == addr_last) begin
            state   <= S_READBACK;
            wr_en_r <= 1'b0;
            addr_r  <= '0;
          end else begin
            addr_r <= addr_r + 1'b1;
          end
        end
        S_READBACK: begin
          if (bus.transfer_done) begin
            state    <= S_DONE;
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            addr_r   <= '0;
          end else if (addr_r == addr_last) begin
            addr_r <= '0;
          end else begin
            addr_r <= addr_r + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.start_signal = start_r;
  assign bus.enable       = enable_r;
  assign bus.wr_en        = wr_en_r;
  assign bus.ram_addr     = addr_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: randomized button/transfer_done stimulus checked
// cycle by cycle against a schedule model of a run (cycle index since the press).
module tb_capture_sequencer;
  localparam int aw       = 4;
  localparam int max_addr = 16;
  localparam int burst    = 5;
  localparam int db       = 4;
  localparam int settle   = 3;
  localparam int cap_start = burst + settle;        // first write cycle of a run
  localparam int rb_start  = cap_start + max_addr;  // first read-sweep cycle of a run

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef logic [aw+4:0] vec_t;  // {start, enable, wr_en, busy, done, ram_addr}

  logic clk = 1'b0;
  logic reset;

  capture_sequencer_if #(.address_width(aw)) bus ();

  capture_sequencer #(
    .address_width  (aw),
    .max_ram_address(max_addr),
    .burst_index    (burst),
    .debounce_cycles(db),
    .settle_cycles  (settle)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Model state
  int m_mode;
  int m_r;
  bit hist[$];
  int low_run;
  int wr_seen;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t expected();
    vec_t v;
    v = '0;
    if (m_mode == M_IDLE) begin
      v = {5'b10000, {aw{1'b0}}};
    end else if (m_mode == M_DONE) begin
      v = {5'b00001, {aw{1'b0}}};
    end else if (m_r < burst) begin
      v = {5'b11010, {aw{1'b0}}};
    end else if (m_r < cap_start) begin
      v = {5'b01010, {aw{1'b0}}};
    end else if (m_r < rb_start) begin
      v = {5'b01110, aw'(m_r - cap_start)};
    end else begin
      v = {5'b01010, aw'((m_r - rb_start) % max_addr)};
    end
    return v;
  endfunction

  function automatic string phase_name();
    if (m_mode == M_IDLE) return "idle";
    if (m_mode == M_DONE) return "done";
    if (m_r < burst) return "prime";
    if (m_r < cap_start) return "settle";
    if (m_r < rb_start) return "capture";
    return "readback";
  endfunction

  function automatic vec_t observed();
    return {bus.start_signal, bus.enable, bus.wr_en, bus.busy, bus.done, bus.ram_addr};
  endfunction

  // Scoreboard comparisons
  task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_r     = 0;
    hist    = '{1'b1, 1'b1};
    low_run = 0;
    wr_seen = 0;
  endtask

  // One rising edge: the button sample two edges old is what the debouncer sees now.
  task automatic model_edge(input bit btn, input bit td);
    bit s;
    bit press;
    hist.push_back(btn);
    s = hist.pop_front();
    if (!s) begin
      if (low_run <= db) low_run++;
    end else begin
      low_run = 0;
    end
    press = !s && (low_run == db);
    if (m_mode == M_RUN) begin
      if (m_r >= rb_start && td) begin
        m_mode = M_DONE;
        check_int("write_count", wr_seen, max_addr);
      end else begin
        m_r++;
      end
    end else if (press) begin
      m_mode  = M_RUN;
      m_r     = 0;
      wr_seen = 0;
    end
  endtask

  // Driver: apply inputs for one cycle, advance model, check just after the edge.
  task automatic step(input bit btn, input bit td);
    bus.push_button_n = btn;
    bus.transfer_done = td;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(btn, td);
    #1;
    if (bus.wr_en === 1'b1) wr_seen++;
    check_vec(phase_name(), observed(), expected());
    @(negedge clk);
  endtask

  task automatic press_button(input int len);
    for (int i = 0; i < len; i++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Drive a run to DONE; td fires on read-sweep cycle 'target'. Noisy runs add
  // transfer_done noise and a full button press inside the capture window.
  task automatic run_until_done(input int target, input bit noisy);
    bit reached;
    int nz;
    bit btn;
    bit td;
    int off;
    reached = 1'b0;
    nz = $urandom_range(0, 6);
    for (int i = 0; i < 300 && !reached; i++) begin
      btn = 1'b1;
      td  = 1'b0;
      if (m_mode == M_RUN && m_r >= rb_start) begin
        td = ((m_r - rb_start) == target);
      end else if (noisy) begin
        td = 1'($urandom_range(0, 1));
        off = m_r - cap_start;
        if (m_mode == M_RUN && off >= nz && off < nz + 6) btn = 1'b0;
      end
      step(btn, td);
      if (m_mode == M_DONE) reached = 1'b1;
    end
    check_int("reached_done", int'(reached), 1);
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "time limit");
  end

  initial begin
    int len;
    int target;
    bit reached;

    // Reset
    reset = 1'b1;
    bus.push_button_n = 1'b1;
    bus.transfer_done = 1'b0;
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    reset = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Short glitches never reach the debounce threshold
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(1, db - 1);
      press_button(len);
      for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom_range(0, 1)));
    end

    // Normal run, 40 read-sweep cycles then a transfer_done pulse
    press_button(10);
    run_until_done(40, 1'b0);

    // DONE holds while idle, transfer_done ignored
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));

    // Rerun from DONE, same capture
    press_button($urandom_range(db, 12));
    run_until_done(40, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Rerun with ignored events during capture and a random sweep length
    target = $urandom_range(0, 40);
    press_button($urandom_range(db, 10));
    run_until_done(target, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

    // Reset abort in the middle of capture at ram_addr 7
    press_button($urandom_range(db, 10));
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (m_mode == M_RUN && m_r == cap_start + 7) reached = 1'b1;
      else step(1'b1, 1'b0);
    end
    check_int("reached_addr7", int'(reached), 1);
    #2;
    reset = 1'b1;
    #1;
    check_vec("reset_abort", observed(), {5'b10000, {aw{1'b0}}});
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

    // Short run after the abort
    press_button(db + 2);
    run_until_done($urandom_range(0, 5), 1'b0);
    step(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
